// File: rtl/oec_blend.sv
// Over-exposure-correction blend: per-lane weighted mix of original and
// corrected pixels. Define OEC_BLEND_BYPASS_EN to add a per-group bypass port.
module oec_blend #(
  parameter int DW_DEC   = 8,
  parameter int DW_IN    = 10,
  parameter int LINE_GRP = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW_IN*4-1:0]   imcin_d,
  input  logic [DW_IN*4-1:0]   imcor,
  input  logic [DW_DEC:0]      m_d,
`ifdef OEC_BLEND_BYPASS_EN
  input  logic                 bypass,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW_IN*4-1:0]   pix_out,
  output logic                 eol_out
);

  localparam int WW = DW_DEC + 1;
  localparam int PW = DW_IN + WW;
  localparam int SW = PW + 1;
  localparam int CW = (LINE_GRP > 1) ? $clog2(LINE_GRP) : 1;

  localparam logic [WW-1:0]    WMAX = {1'b1, {DW_DEC{1'b0}}};
  localparam logic [CW-1:0]    COL_LAST = CW'(LINE_GRP - 1);
  localparam logic [SW-1:0]    RND = SW'(1) << (DW_DEC - 1);
  localparam logic [DW_IN-1:0] PMAX = '1;

  logic adv;
  logic xfer;
  logic byp;

  logic [CW-1:0] col_q, col_d;
  logic          v1_q, eol1_q;
  logic [PW-1:0] pc_q [4];
  logic [PW-1:0] po_q [4];
  logic [PW-1:0] pc_d [4];
  logic [PW-1:0] po_d [4];

  logic [DW_IN*4-1:0] pix_q, pix_d;
  logic               eol_q, ov_q;

  logic [WW-1:0] mc, wo;

  assign adv      = !ov_q | out_ready;
  assign in_ready = adv;
  assign xfer     = in_valid & adv;

`ifdef OEC_BLEND_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  // Weights above full scale saturate; bypass forces the original through.
  always_comb begin
    mc = (m_d > WMAX) ? WMAX : m_d;
    if (byp) begin
      mc = '0;
    end
    wo = WMAX - mc;
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      pc_d[l] = PW'(mc) * PW'(imcor[l*DW_IN +: DW_IN]);
      po_d[l] = PW'(wo) * PW'(imcin_d[l*DW_IN +: DW_IN]);
    end
  end

  always_comb begin
    logic [SW-1:0] s;
    logic [SW-1:0] r;
    pix_d = '0;
    for (int l = 0; l < 4; l++) begin
      s = SW'(pc_q[l]) + SW'(po_q[l]) + RND;
      r = s >> DW_DEC;
      if (r > SW'(PMAX)) begin
        pix_d[l*DW_IN +: DW_IN] = PMAX;
      end else begin
        pix_d[l*DW_IN +: DW_IN] = r[DW_IN-1:0];
      end
    end
  end

  always_comb begin
    col_d = col_q;
    if (xfer) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      v1_q   <= 1'b0;
      eol1_q <= 1'b0;
      for (int l = 0; l < 4; l++) begin
        pc_q[l] <= '0;
        po_q[l] <= '0;
      end
    end else if (adv) begin
      col_q  <= col_d;
      v1_q   <= xfer;
      eol1_q <= (col_q == COL_LAST);
      for (int l = 0; l < 4; l++) begin
        pc_q[l] <= pc_d[l];
        po_q[l] <= po_d[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
      eol_q <= 1'b0;
      ov_q  <= 1'b0;
    end else if (adv) begin
      pix_q <= pix_d;
      eol_q <= eol1_q;
      ov_q  <= v1_q;
    end
  end

  assign out_valid = ov_q;
  assign pix_out   = pix_q;
  assign eol_out   = eol_q;

endmodule

// File: tb/tb_oec_blend.sv
// Scoreboard bench for oec_blend with LINE_GRP=4: directed blends,
// streaming, backpressure, line wrap and reset during a stall.
module tb_oec_blend;

  localparam int DW_IN  = 10;
  localparam int DW_DEC = 8;
  localparam int LG     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] imcin_d = '0;
  logic [39:0] imcor = '0;
  logic [8:0]  m_d = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [39:0] pix_out;
  logic        eol_out;
`ifdef OEC_BLEND_BYPASS_EN
  logic        bypass = 1'b0;
`endif

  oec_blend #(
    .DW_DEC(DW_DEC),
    .DW_IN(DW_IN),
    .LINE_GRP(LG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .imcin_d(imcin_d),
    .imcor(imcor),
    .m_d(m_d),
`ifdef OEC_BLEND_BYPASS_EN
    .bypass(bypass),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pix_out(pix_out),
    .eol_out(eol_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] pix;
    logic        eol;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int col = 0;
  int waits = 0;

  function automatic logic [39:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  function automatic logic [39:0] pk1(input int x);
    return pk(x, x, x, x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [39:0] o, input logic [39:0] c,
                      input logic [8:0] m, input logic [39:0] e);
    int n;
    @(negedge clk);
    imcin_d  = o;
    imcor    = c;
    m_d      = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    waits += n;
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck low for %0d cycles", n);
      in_valid = 1'b0;
    end else begin
      q.push_back({e, 1'(col == LG - 1)});
      col = (col + 1) % LG;
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d outputs missing, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_pix_out"}, pix_out, 0);
    chk({tag, "_eol_out"}, eol_out, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_checks(tag);
    q.delete();
    col = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops on every output transfer, checks held data while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        if (q.size() > 0) begin
          chk("stall_pix", pix_out, q[0].pix);
          chk("stall_eol", eol_out, q[0].eol);
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_output: got %0h with no expected group",
                   pix_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pix", pix_out, e.pix);
          chk("eol", eol_out, e.eol);
        end
      end
    end
  end

  initial begin
    #1 reset_checks("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Weight extremes with latency check.
    send(pk1(100), pk1(900), 9'd0, pk1(100));
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency_c1_valid", out_valid, 0);
    @(negedge clk);
    chk("latency_c2_valid", out_valid, 1);
    send(pk1(100), pk1(900), 9'd256, pk1(900));
    send(pk1(100), pk1(900), 9'd128, pk1(500));
    send(pk1(100), pk1(900), 9'd300, pk1(900));
    send(pk1(0), pk1(1023), 9'd256, pk1(1023));
    send(pk1(0), pk(127, 128, 383, 1023), 9'd1, pk(0, 1, 1, 4));
    send(pk(0, 1000, 0, 1000), pk(1000, 0, 1000, 0), 9'd64,
         pk(250, 750, 250, 750));
    send(pk1(0), pk1(0), 9'd511, pk1(0));
    idle(1);
    drain();

    // Streaming: alternate full-original and full-corrected groups.
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      logic [39:0] o, c;
      o = pk(100 + i*8, 101 + i*8, 102 + i*8, 103 + i*8);
      c = pk(500 + i*8, 501 + i*8, 502 + i*8, 503 + i*8);
      send(o, c, (i % 2 == 0) ? 9'd0 : 9'd256, (i % 2 == 0) ? o : c);
    end
    chk("stream_no_stall", waits, 0);
    idle(1);
    drain();

    // Backpressure: five stalled cycles in the middle of a stream.
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [39:0] o, c;
          o = pk(200 + i*4, 201 + i*4, 202 + i*4, 203 + i*4);
          c = pk(600 + i*4, 601 + i*4, 602 + i*4, 603 + i*4);
          send(o, c, (i % 3 == 0) ? 9'd0 : 9'd256, (i % 3 == 0) ? o : c);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    idle(1);
    drain();

    // Line wrap with bubbles: eol lands on groups 4 and 8.
    do_reset("rst_line");
    for (int i = 0; i < 10; i++) begin
      send(pk1(10), pk1(20 + i), 9'd256, pk1(20 + i));
      idle($urandom_range(0, 2));
    end
    idle(1);
    drain();

    // Reset while stalled with valid output pending.
    @(posedge clk);
    #2 out_ready = 1'b0;
    send(pk1(11), pk1(22), 9'd0, pk1(11));
    send(pk1(33), pk1(44), 9'd256, pk1(44));
    idle(2);
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 reset_checks("rst_stall");
    q.delete();
    col = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(pk1(300 + i), pk1(50), 9'd0, pk1(300 + i));
    end
`ifdef OEC_BLEND_BYPASS_EN
    @(negedge clk);
    bypass = 1'b1;
    send(pk1(37), pk1(900), 9'd256, pk1(37));
    @(negedge clk);
    bypass = 1'b0;
    send(pk1(37), pk1(900), 9'd256, pk1(900));
`endif
    idle(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
